enc8to3_queue: RTL and testbench
================================

Name: enc8to3_queue

Overview:
Sequential 8-to-3 encoder. It is the encoding-side counterpart to the 3-to-8 enable decoder. It latches one-cycle request pulses on eight lines into a pending register. It presents one pending index at a time as a 3-bit code with a valid/ack handshake, so codes can drive a downstream dec3to8 or a consumer one at a time. Simultaneous and overlapping requests are never lost; they are queued per line and served in priority order.

Parameters:
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = rotating priority starting after the last served index.

Ports:
clk  input  1  clock, rising-edge.
resetn  input  1  asynchronous active-low reset.
en  input  1  request capture enable; when 0, d is ignored.
d  input  8  request pulses, one bit per line, sampled each rising edge.
y  output  3  encoded index of the request being presented.
valid  output  1  y holds a pending request.
ack  input  1  consumer accepts y; meaningful only when valid=1.
pend  output  8  current pending-request register, for debug/status.
ovf  output  1  sticky flag: a request arrived on a line that was already pending.

Behaviour:
- Reset (resetn=0, asynchronous, any time including mid-handshake):
  - pend=8'h00, y=3'b000, valid=0, ovf=0, state=IDLE.
  - Round-robin pointer last=3'd7, so the first search starts at index 0.
  - Outputs stay at these values while resetn=0. The first capture happens on the first edge after release.
- Capture:
  - Every edge: pend <= (pend & ~clr) | (d & {8{en}}).
  - clr is onehot(y) when valid&&ack, otherwise 0.
  - Set wins over clear: if d[i] rises in the same cycle that i is acked, pend[i] stays 1 and ovf is not set.
- Overflow:
  - ovf <= 1 when en && d[i] && pend[i] && !(valid&&ack&&y==i), for any i.
  - ovf is sticky; only reset clears it. The duplicate request is merged, not counted.
- Selection function sel(p):
  - Fixed mode: lowest set index of p.
  - RR mode: first set index scanning last+1, last+2, ... with wrap 7->0.
  - Selection only looks at the registered pend value, never at raw d.
- FSM states IDLE and PRESENT:
  - IDLE: if pend!=0, then y<=sel(pend), valid<=1, go to PRESENT. Otherwise stay, valid=0.
  - PRESENT with ack=0: y and valid hold stable. No preemption, even if a higher-priority line becomes pending.
  - PRESENT with ack=1: bit y is cleared. Let rem = pend & ~onehot(y).
    - If rem!=0: y<=sel(rem), valid stays 1, remain in PRESENT. This gives back-to-back service with no bubble.
    - Otherwise: valid<=0, go to IDLE.
    - Requests arriving in the ack cycle are not in rem; they are served later.
  - In RR mode, last<=y on each accepted ack.
- Latency: a d pulse at edge t sets pend at edge t. From IDLE, valid=1 with that code after edge t+1.
- Throughput: one code per cycle when ack is held high.
- ack while valid=0 is ignored.
- en=0 blocks capture only; already-pending requests are still served.

Test Plan:
- Reset mid-handshake: pend=8'h0C, valid=1, y=2; pulse resetn low between edges -> pend=0, valid=0, y=0, ovf=0 immediately, with no clk edge needed.
- Single request: en=1, d=8'h20 for one cycle, ack tied 1 -> valid=1, y=5 one cycle later; then valid=0, pend=0.
- Fixed priority burst (ROUND_ROBIN=0): d=8'hA5 for one cycle, ack=1 -> y sequence 0,2,5,7 on consecutive cycles with valid=1 throughout, then valid=0.
- Hold and no preemption: d=8'h10 with ack=0, then d=8'h01 -> y stays 4 until ack, then y=0.
- Overflow and set-wins: with pend[3]=1 and ack=0, pulse d[3] -> ovf=1 and stays 1. After reset, pulse d[3] in the same cycle y=3 is acked -> pend[3]=1, ovf=0, and y=3 is presented again.
- Round robin (ROUND_ROBIN=1): hold d=8'h81 every cycle, ack=1 -> y alternates 0,7,0,7. With en=0 and d=8'hFF -> pend is unchanged.

Source files
------------

// File: rtl/enc8to3_queue_if.sv
// Request/code handshake bundle for the 8-to-3 queueing encoder.
// master = producer/consumer side, slave = the encoder.
interface enc8to3_queue_if;
  logic       en;
  logic [7:0] d;
  logic [2:0] y;
  logic       valid;
  logic       ack;
  logic [7:0] pend;
  logic       ovf;

  modport master (
    output en, d, ack,
    input  y, valid, pend, ovf
  );

  modport slave (
    input  en, d, ack,
    output y, valid, pend, ovf
  );
endinterface

// File: rtl/enc8to3_queue.sv
// Sequential 8-to-3 encoder: latches request pulses into a pending
// register and presents one index at a time over valid/ack.
module enc8to3_queue #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  enc8to3_queue_if.slave   q
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] y_q, y_d;
  logic [2:0] last_q, last_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;

  logic       acc;
  logic [7:0] clr;
  logic [7:0] cap;
  logic [7:0] rem;

  // Scan starts after 'last' in rotating mode, at 0 otherwise.
  function automatic logic [2:0] sel(
    input logic [7:0] p,
    input logic [2:0] last
  );
    logic [2:0] idx;
    logic       found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ROUND_ROBIN ? last + 3'(k + 1) : 3'(k);
      if (!found && p[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    acc     = valid_q && q.ack;
    clr     = acc ? (8'h01 << y_q) : 8'h00;
    cap     = q.d & {8{q.en}};
    rem     = pend_q & ~clr;
    pend_d  = rem | cap;
    ovf_d   = ovf_q | (|(cap & pend_q & ~clr));
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q != 8'h00) begin
          y_d     = sel(pend_q, last_q);
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (q.ack) begin
          if (ROUND_ROBIN) last_d = y_q;
          if (rem != 8'h00) begin
            y_d = sel(rem, ROUND_ROBIN ? y_q : last_q);
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pend_q  <= 8'h00;
      y_q     <= 3'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  assign q.y     = y_q;
  assign q.valid = valid_q;
  assign q.pend  = pend_q;
  assign q.ovf   = ovf_q;

endmodule

// File: tb/tb_enc8to3_queue.sv
// Bench for enc8to3_queue: fixed and round-robin instances driven
// together and compared against a queue-level reference model.
module tb_enc8to3_queue;

  logic clk;
  logic resetn;

  enc8to3_queue_if f_if ();
  enc8to3_queue_if r_if ();

  enc8to3_queue #(.ROUND_ROBIN(1'b0)) u_fix (
    .clk    (clk),
    .resetn (resetn),
    .q      (f_if)
  );

  enc8to3_queue #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk    (clk),
    .resetn (resetn),
    .q      (r_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state, index 0 = fixed, 1 = round robin
  logic [7:0] mpend [2];
  bit         mv    [2];
  int         my    [2];
  int         ml    [2];
  bit         mo    [2];

  function automatic int pick(input logic [7:0] p, input int last, input bit rr);
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = rr ? (last + 1 + k) % 8 : k;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void mreset();
    for (int m = 0; m < 2; m++) begin
      mpend[m] = 8'h00;
      mv[m]    = 1'b0;
      my[m]    = 0;
      ml[m]    = 7;
      mo[m]    = 1'b0;
    end
  endfunction

  function automatic void mstep(input int m, input bit e, input logic [7:0] dd, input bit a);
    logic [7:0] cap, old, rem;
    int served;
    bit rr;
    rr     = (m == 1);
    cap    = e ? dd : 8'h00;
    old    = mpend[m];
    rem    = old;
    served = -1;
    if (mv[m] && a) begin
      served = my[m];
      rem[served] = 1'b0;
    end
    for (int i = 0; i < 8; i++)
      if (cap[i] && old[i] && i != served) mo[m] = 1'b1;
    mpend[m] = rem | cap;
    if (!mv[m]) begin
      if (old != 8'h00) begin
        my[m] = pick(old, ml[m], rr);
        mv[m] = 1'b1;
      end
    end else if (served >= 0) begin
      if (rr) ml[m] = served;
      if (rem != 8'h00) my[m] = pick(rem, ml[m], rr);
      else mv[m] = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " fix valid"}, {7'd0, f_if.valid}, {7'd0, mv[0]});
    chk({ph, " fix pend"}, f_if.pend, mpend[0]);
    chk({ph, " fix ovf"}, {7'd0, f_if.ovf}, {7'd0, mo[0]});
    if (mv[0]) chk({ph, " fix y"}, {5'd0, f_if.y}, 8'(my[0]));
    chk({ph, " rr valid"}, {7'd0, r_if.valid}, {7'd0, mv[1]});
    chk({ph, " rr pend"}, r_if.pend, mpend[1]);
    chk({ph, " rr ovf"}, {7'd0, r_if.ovf}, {7'd0, mo[1]});
    if (mv[1]) chk({ph, " rr y"}, {5'd0, r_if.y}, 8'(my[1]));
  endtask

  task automatic cyc(input string ph, input bit e, input logic [7:0] dd, input bit a);
    f_if.en = e; f_if.d = dd; f_if.ack = a;
    r_if.en = e; r_if.d = dd; r_if.ack = a;
    @(posedge clk);
    mstep(0, e, dd, a);
    mstep(1, e, dd, a);
    #1;
    check_all(ph);
  endtask

  // asserts reset between edges and checks outputs without any edge
  task automatic areset(input string ph);
    #2;
    resetn = 1'b0;
    #1;
    mreset();
    chk({ph, " fix y rst"}, {5'd0, f_if.y}, 8'h00);
    chk({ph, " rr y rst"}, {5'd0, r_if.y}, 8'h00);
    check_all(ph);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    f_if.en = 1'b0; f_if.d = 8'h00; f_if.ack = 1'b0;
    r_if.en = 1'b0; r_if.d = 8'h00; r_if.ack = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;

    // reset in the middle of a handshake
    cyc("mid0", 1, 8'h0C, 0);
    cyc("mid1", 0, 8'h00, 0);
    chk("mid fix y=2", {5'd0, f_if.y}, 8'h02);
    areset("midrst");

    // single request, ack held
    cyc("single0", 1, 8'h20, 1);
    cyc("single1", 0, 8'h00, 1);
    chk("single y=5", {5'd0, f_if.y}, 8'h05);
    cyc("single2", 0, 8'h00, 1);
    cyc("single3", 0, 8'h00, 1);

    // burst: fixed order 0,2,5,7
    cyc("burst", 1, 8'hA5, 1);
    for (int i = 0; i < 5; i++) cyc("burst", 0, 8'h00, 1);

    // hold with no preemption
    cyc("hold", 1, 8'h10, 0);
    cyc("hold", 1, 8'h01, 0);
    cyc("hold", 0, 8'h00, 0);
    chk("hold y=4", {5'd0, f_if.y}, 8'h04);
    for (int i = 0; i < 3; i++) cyc("hold", 0, 8'h00, 1);

    // overflow on an already-pending line
    cyc("ovf", 1, 8'h08, 0);
    cyc("ovf", 0, 8'h00, 0);
    cyc("ovf", 1, 8'h08, 0);
    chk("ovf set", {7'd0, f_if.ovf}, 8'h01);
    cyc("ovf", 0, 8'h00, 1);
    cyc("ovf", 0, 8'h00, 0);
    areset("ovfrst");

    // set wins over clear in the ack cycle
    cyc("setwin", 1, 8'h08, 0);
    cyc("setwin", 0, 8'h00, 0);
    cyc("setwin", 1, 8'h08, 1);
    chk("setwin pend3", f_if.pend, 8'h08);
    chk("setwin ovf0", {7'd0, f_if.ovf}, 8'h00);
    cyc("setwin", 0, 8'h00, 0);
    chk("setwin y=3", {5'd0, f_if.y}, 8'h03);
    cyc("setwin", 0, 8'h00, 1);
    cyc("setwin", 0, 8'h00, 1);
    areset("rrrst");

    // round robin alternation with 0x81 held
    for (int i = 0; i < 8; i++) cyc("rr81", 1, 8'h81, 1);
    // capture disabled, pending unchanged
    for (int i = 0; i < 3; i++) cyc("en0", 0, 8'hFF, 0);
    for (int i = 0; i < 4; i++) cyc("drain", 0, 8'h00, 1);

    // random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) areset("rndrst");
      cyc("rnd", ($urandom_range(0, 3) != 0),
          8'($urandom() & $urandom()),
          ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
